// File: rtl/golden_nonce_reporter.sv
// Queues golden nonces from the hashing core and streams each one to the UART
// as four little-endian bytes. Optional GOLDEN_NONCE_DEDUP_EN drops repeats of the last accepted nonce.
module golden_nonce_reporter #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     golden_valid,
    input  logic [31:0]              golden_nonce,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] pending
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t                     state;
    logic [31:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [31:0]                shift_reg;
    logic [1:0]                 byte_cnt;
    logic                       fifo_full, fifo_empty;
    logic                       pop, push_req, push, drop;

    assign fifo_full  = (pending == DEPTH_CNT);
    assign fifo_empty = (pending == '0);
    // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
    assign pop  = (state == LOAD);
    assign push = push_req && (!fifo_full || pop);
    assign drop = push_req && fifo_full && !pop;

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic [31:0] last_nonce;
    logic        last_vld;

    assign push_req = golden_valid && !(last_vld && (last_nonce == golden_nonce));

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            last_vld   <= 1'b0;
            last_nonce <= '0;
        end else if (push) begin
            last_vld   <= 1'b1;
            last_nonce <= golden_nonce;
        end
    end
`else
    assign push_req = golden_valid;
`endif

    always_ff @(posedge hash_clk) begin
        if (!reset && push)
            fifo_mem[wr_ptr] <= golden_nonce;
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            case ({push, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // tx_data is the low byte of the shift register, so it cannot change without a shift.
    assign tx_data = shift_reg[7:0];

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty)
                        state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_mem[rd_ptr];
                    byte_cnt  <= '0;
                    tx_valid  <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        shift_reg <= {8'h00, shift_reg[31:8]};
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= fifo_empty ? IDLE : LOAD;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
